// File: rtl/data_stack_pkg.sv
// Shared encodings for the data stack unit: request opcodes, control FSM states
// and the bit positions used in rsp_err.
package data_stack_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

endpackage

// File: rtl/sp_ram.sv
// Single-port word memory. Writes are synchronous and the read port is registered.
// A read that hits the word being written returns the old contents.
module sp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_stack_unit.sv
// Word-addressed LOAD/STORE plus a downward-growing stack on one single-port RAM.
// A wide (two-word) op takes two RAM cycles, so the unit spends one extra cycle in SECOND.
module data_stack_unit
  import data_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic                    req_wide,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [ADDR_WIDTH-1:0]   sp
);

  localparam logic [ADDR_WIDTH-1:0] SP_TOP = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sp_q, sp_d;
  logic                    pend_q, pend_d;
  logic                    pend_read_q, pend_read_d;
  logic                    pend_wide_q, pend_wide_d;
  logic [1:0]              pend_err_q, pend_err_d;
  logic [ADDR_WIDTH-1:0]   sec_addr_q, sec_addr_d;
  logic [ADDR_WIDTH-1:0]   sec_sp_q, sec_sp_d;
  logic                    sec_we_q, sec_we_d;
  logic [DATA_WIDTH-1:0]   sec_wdata_q, sec_wdata_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_err_q, rsp_err_d;

  op_e                     op;
  logic [ADDR_WIDTH-1:0]   n_words;
  logic                    ovf, unf;
  logic [DATA_WIDTH-1:0]   wd_lo, wd_hi;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;

  assign op      = op_e'(req_op);
  assign wd_lo   = req_wdata[DATA_WIDTH-1:0];
  assign wd_hi   = req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign n_words = req_wide ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
  // Bounds keep sp in [0, SP_TOP] without wrap, so address 0 is never pushed to.
  assign ovf     = (op == OP_PUSH) && (sp_q < n_words);
  assign unf     = (op == OP_POP) && (sp_q > SP_TOP - n_words);

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pend_d      = 1'b0;
    pend_read_d = pend_read_q;
    pend_wide_d = pend_wide_q;
    pend_err_d  = pend_err_q;
    sec_addr_d  = sec_addr_q;
    sec_sp_d    = sec_sp_q;
    sec_we_d    = sec_we_q;
    sec_wdata_d = sec_wdata_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_we      = 1'b0;
    ram_addr    = req_addr;
    ram_wdata   = wd_lo;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pend_read_d         = (op == OP_LOAD) || (op == OP_POP);
          pend_wide_d         = req_wide;
          pend_err_d          = '0;
          pend_err_d[ERR_OVF] = ovf;
          pend_err_d[ERR_UNF] = unf;
          sec_we_d            = 1'b0;
          sec_sp_d            = sp_q;
          sec_addr_d          = req_addr + ADDR_WIDTH'(1);
          sec_wdata_d         = wd_hi;
          case (op)
            OP_LOAD: ;
            OP_STORE: begin
              ram_we   = 1'b1;
              sec_we_d = 1'b1;
            end
            OP_PUSH: begin
              // Wide push writes the high word first so it lands at the higher address.
              ram_addr    = sp_q;
              ram_we      = !ovf;
              ram_wdata   = req_wide ? wd_hi : wd_lo;
              sec_addr_d  = sp_q - ADDR_WIDTH'(1);
              sec_wdata_d = wd_lo;
              sec_we_d    = 1'b1;
              sec_sp_d    = sp_q - ADDR_WIDTH'(2);
              if (!req_wide && !ovf) sp_d = sp_q - ADDR_WIDTH'(1);
            end
            OP_POP: begin
              ram_addr   = sp_q + ADDR_WIDTH'(1);
              sec_addr_d = sp_q + ADDR_WIDTH'(2);
              sec_sp_d   = sp_q + ADDR_WIDTH'(2);
              if (!req_wide && !unf) sp_d = sp_q + ADDR_WIDTH'(1);
            end
            default: ;
          endcase
          if (req_wide && !ovf && !unf) state_d = ST_SECOND;
          else                          pend_d  = 1'b1;
        end
      end
      ST_SECOND: begin
        ram_addr  = sec_addr_q;
        ram_we    = sec_we_q;
        ram_wdata = sec_wdata_q;
        lo_d      = ram_rdata;
        sp_d      = sec_sp_q;
        pend_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = pend_err_q;
      if (pend_read_q && (pend_err_q == 2'b00))
        rsp_rdata_d = pend_wide_q ? {ram_rdata, lo_q} : {{DATA_WIDTH{1'b0}}, ram_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sp_q        <= SP_TOP;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
    pend_read_q <= pend_read_d;
    pend_wide_q <= pend_wide_d;
    pend_err_q  <= pend_err_d;
    sec_addr_q  <= sec_addr_d;
    sec_sp_q    <= sec_sp_d;
    sec_we_q    <= sec_we_d;
    sec_wdata_q <= sec_wdata_d;
    lo_q        <= lo_d;
  end

  sp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we && !rst),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign sp        = sp_q;

endmodule
